// File: rtl/fp16_to_int16_converter.sv
// fp16_to_int16_converter: IEEE-754 half precision -> signed int16, round-to-nearest-even,
// using an iterative shifter that moves SHIFT_PER_CYCLE bit positions per cycle.
// Ports: clock/reset (async, active-high); in_valid/in_ready/operand (input handshake);
//        out_valid/out_ready/result plus overflow/NaN/inexact/zero flags (output handshake).
module fp16_to_int16_converter #(
   parameter int          SHIFT_PER_CYCLE = 1,        // legal: 1, 2, 4
   parameter logic [15:0] NAN_VALUE       = 16'h8000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] operand,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] result,
   output logic        overflow_flag,
   output logic        NaN_flag,
   output logic        inexact_flag,
   output logic        zero_flag
);

   typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

   state_t      state_q, state_d;
   logic        in_ready_q, in_ready_d;
   logic        out_valid_q, out_valid_d;
   logic        sign_q, sign_d;
   logic [4:0]  exp_q, exp_d;
   logic [9:0]  man_q, man_d;
   logic [15:0] mag_q, mag_d;          // working magnitude being shifted
   logic        guard_q, guard_d;      // last bit shifted out on the right
   logic        sticky_q, sticky_d;    // OR of every earlier bit shifted out
   logic [3:0]  cnt_q, cnt_d;          // remaining shift positions
   logic        left_q, left_d;        // shift direction
   logic [15:0] result_q, result_d;
   logic        ovf_q, ovf_d;
   logic        nan_q, nan_d;
   logic        inx_q, inx_d;
   logic        zero_q, zero_d;

   // ---------------------------------------------------------------
   // Operand classification at accept time
   // ---------------------------------------------------------------
   logic [4:0] op_exp;
   logic [9:0] op_man;
   logic       op_special;   // result fully decided by exponent range, no shifting
   logic       op_left;
   logic [3:0] op_cnt;

   always_comb begin
      op_exp     = operand[14:10];
      op_man     = operand[9:0];
      op_special = (op_exp >= 5'd30) || (op_exp <= 5'd13);
      op_left    = (op_exp >= 5'd25);
      if (op_special)   op_cnt = 4'd0;
      else if (op_left) op_cnt = 4'(op_exp - 5'd25);
      else              op_cnt = 4'(5'd25 - op_exp);
   end

   // ---------------------------------------------------------------
   // One SHIFT cycle: up to SHIFT_PER_CYCLE single-bit steps
   // ---------------------------------------------------------------
   logic [15:0] sh_mag;
   logic        sh_guard;
   logic        sh_sticky;
   logic [3:0]  sh_cnt;

   always_comb begin
      sh_mag    = mag_q;
      sh_guard  = guard_q;
      sh_sticky = sticky_q;
      sh_cnt    = cnt_q;
      for (int i = 0; i < SHIFT_PER_CYCLE; i++) begin
         if (sh_cnt != 4'd0) begin
            if (left_q) begin
               sh_mag = {sh_mag[14:0], 1'b0};
            end else begin
               // previous guard bit is now an "earlier" bit, so it joins sticky
               sh_sticky = sh_sticky | sh_guard;
               sh_guard  = sh_mag[0];
               sh_mag    = {1'b0, sh_mag[15:1]};
            end
            sh_cnt = sh_cnt - 4'd1;
         end
      end
   end

   // ---------------------------------------------------------------
   // ROUND: special-case results or RNE on the shifted magnitude
   // ---------------------------------------------------------------
   logic        rnd_up;
   logic [15:0] rnd_mag;
   logic [15:0] rd_result;
   logic        rd_ovf, rd_nan, rd_inx, rd_zero;

   always_comb begin
      rnd_up    = guard_q & (sticky_q | mag_q[0]);
      rnd_mag   = mag_q + {15'd0, rnd_up};
      rd_result = 16'h0000;
      rd_ovf    = 1'b0;
      rd_nan    = 1'b0;
      rd_inx    = 1'b0;
      rd_zero   = 1'b0;
      if (exp_q == 5'd31 && man_q != 10'd0) begin
         rd_result = NAN_VALUE;
         rd_nan    = 1'b1;
      end else if (exp_q == 5'd30 && sign_q && man_q == 10'd0) begin
         // -32768 is representable exactly
         rd_result = 16'h8000;
      end else if (exp_q >= 5'd30) begin
         rd_result = sign_q ? 16'h8000 : 16'h7FFF;
         rd_ovf    = 1'b1;
      end else if (exp_q == 5'd0 && man_q == 10'd0) begin
         rd_zero   = 1'b1;
      end else if (exp_q <= 5'd13) begin
         // |value| < 0.5 always rounds to zero
         rd_zero   = 1'b1;
         rd_inx    = 1'b1;
      end else begin
         rd_result = sign_q ? (16'd0 - rnd_mag) : rnd_mag;
         rd_inx    = guard_q | sticky_q;
         rd_zero   = (rnd_mag == 16'd0);
      end
   end

   // ---------------------------------------------------------------
   // FSM next state / datapath
   // ---------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      sign_d      = sign_q;
      exp_d       = exp_q;
      man_d       = man_q;
      mag_d       = mag_q;
      guard_d     = guard_q;
      sticky_d    = sticky_q;
      cnt_d       = cnt_q;
      left_d      = left_q;
      result_d    = result_q;
      ovf_d       = ovf_q;
      nan_d       = nan_q;
      inx_d       = inx_q;
      zero_d      = zero_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               sign_d   = operand[15];
               exp_d    = op_exp;
               man_d    = op_man;
               mag_d    = {5'd0, 1'b1, op_man};
               guard_d  = 1'b0;
               sticky_d = 1'b0;
               cnt_d    = op_cnt;
               left_d   = op_left;
               ovf_d    = 1'b0;
               nan_d    = 1'b0;
               inx_d    = 1'b0;
               zero_d   = 1'b0;
               state_d  = (op_special || op_cnt == 4'd0) ? ROUND : SHIFT;
            end
         end
         SHIFT: begin
            mag_d    = sh_mag;
            guard_d  = sh_guard;
            sticky_d = sh_sticky;
            cnt_d    = sh_cnt;
            if (sh_cnt == 4'd0) state_d = ROUND;
         end
         ROUND: begin
            result_d = rd_result;
            ovf_d    = rd_ovf;
            nan_d    = rd_nan;
            inx_d    = rd_inx;
            zero_d   = rd_zero;
            state_d  = DONE;
         end
         DONE: begin
            // out_valid is registered from the DONE state, so the handshake
            // only completes once it is actually visible to the consumer
            out_valid_d = 1'b1;
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      in_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         sign_q      <= 1'b0;
         exp_q       <= 5'd0;
         man_q       <= 10'd0;
         mag_q       <= 16'd0;
         guard_q     <= 1'b0;
         sticky_q    <= 1'b0;
         cnt_q       <= 4'd0;
         left_q      <= 1'b0;
         result_q    <= 16'd0;
         ovf_q       <= 1'b0;
         nan_q       <= 1'b0;
         inx_q       <= 1'b0;
         zero_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         sign_q      <= sign_d;
         exp_q       <= exp_d;
         man_q       <= man_d;
         mag_q       <= mag_d;
         guard_q     <= guard_d;
         sticky_q    <= sticky_d;
         cnt_q       <= cnt_d;
         left_q      <= left_d;
         result_q    <= result_d;
         ovf_q       <= ovf_d;
         nan_q       <= nan_d;
         inx_q       <= inx_d;
         zero_q      <= zero_d;
      end
   end

   assign in_ready      = in_ready_q;
   assign out_valid     = out_valid_q;
   assign result        = result_q;
   assign overflow_flag = ovf_q;
   assign NaN_flag      = nan_q;
   assign inexact_flag  = inx_q;
   assign zero_flag     = zero_q;

endmodule
